// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types for the instruction fetch unit.
// Entries carry a full 30-bit word address, so ADDR_WIDTH is limited to 32.
package fetch_unit_pkg;

  localparam int INSN_WIDTH = 32;
  localparam int MAX_WADDR_WIDTH = 30;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [MAX_WADDR_WIDTH-1:0] addr;
    logic [INSN_WIDTH-1:0]      insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small circular FIFO used for both the address tags and
// the instruction buffer; flush empties it in a single cycle.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == FULL_COUNT;
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with an address tag queue,
// redirect drain of stale responses and a buffer facing Decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDR_WIDTH-1:2]   imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [INSN_WIDTH-1:0]   imem_rsp_data,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:2]   redirect_addr,
  output logic                    insn_valid,
  input  logic                    insn_ready,
  output logic [ADDR_WIDTH-1:2]   insn_addr,
  output logic [INSN_WIDTH-1:0]   insn
);

  localparam int WA = ADDR_WIDTH - 2;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:2] RESET_PC =
    RESET_ADDR[ADDR_WIDTH-1:2];

  fetch_state_t state;
  fetch_state_t state_next;

  logic [ADDR_WIDTH-1:2] pc;
  logic [ADDR_WIDTH-1:2] tag_head;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         inflight_next;
  logic [CW-1:0]         stale;
  logic [CW-1:0]         stale_next;
  logic [CW-1:0]         tag_count;
  logic [CW-1:0]         buf_count;
  logic [CW:0]           occupancy;
  logic                  req_fire;
  logic                  rsp_ok;
  logic                  rsp_fresh;
  logic                  buf_push;
  logic                  buf_pop;
  logic                  tag_full;
  logic                  tag_empty;
  logic                  buf_full;
  logic                  buf_empty;
  fetch_entry_t          buf_in;
  fetch_entry_t          buf_head;

  assign occupancy = {1'b0, inflight} + {1'b0, buf_count};
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_ok    = imem_rsp_valid && inflight != '0;
  assign rsp_fresh = rsp_ok && stale == '0;
  assign buf_push  = rsp_fresh && !redirect_valid;
  assign buf_pop   = insn_valid && insn_ready;

  assign inflight_next = inflight
                       + {{(CW-1){1'b0}}, req_fire}
                       - {{(CW-1){1'b0}}, rsp_ok};

  // Stale counts what is still in flight once this cycle settles.
  always_comb begin
    stale_next = stale;
    if (redirect_valid) begin
      stale_next = inflight_next;
    end else if (rsp_ok && stale != '0) begin
      stale_next = stale - 1'b1;
    end
  end

  always_comb begin
    buf_in.addr = MAX_WADDR_WIDTH'(tag_head);
    buf_in.insn = imem_rsp_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      DRAIN:   if (stale_next == '0) state_next = RUN;
      default: state_next = BOOT;
    endcase
    if (redirect_valid) begin
      state_next = (stale_next != '0) ? DRAIN : RUN;
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (state == RUN && !redirect_valid &&
        occupancy < DEPTH_LIMIT) begin
      imem_req_valid = 1'b1;
    end
  end

  assign imem_req_addr = pc;
  assign insn_valid    = !buf_empty;
  assign insn_addr     = buf_head.addr[WA-1:0];
  assign insn          = buf_head.insn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      stale    <= '0;
    end else begin
      inflight <= inflight_next;
      stale    <= stale_next;
      if (redirect_valid) begin
        pc <= redirect_addr;
      end else if (req_fire) begin
        pc <= pc + 1'b1;
      end
    end
  end

  fetch_queue #(
    .WIDTH (WA),
    .DEPTH (QUEUE_DEPTH)
  ) tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .data  (pc),
    .pop   (rsp_fresh),
    .flush (redirect_valid),
    .head  (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) insn_q (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .data  (buf_in),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .head  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  a_rsp_outstanding: assert property (
    @(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> inflight != '0)
    else $error("fetch_unit: response with nothing in flight ignored");

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(buf_push && buf_full) && !(req_fire && tag_full));

  a_tag_present: assert property (
    @(posedge clk) disable iff (!rst)
    rsp_fresh |-> !tag_empty);

  a_tag_tracks: assert property (
    @(posedge clk) disable iff (!rst)
    state != DRAIN |-> tag_count == inflight);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic against a memory model
// and an expected-stream model of the fetch unit.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:2] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:2] redirect_addr;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:2] insn_addr;
  logic [31:0] insn;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_WIDTH  (32),
    .RESET_ADDR  (32'h0000_0000),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_addr      (insn_addr),
    .insn           (insn)
  );

  typedef struct {
    logic [29:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       mq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          buffered;
  logic [29:0] exp_req;
  logic [29:0] exp_insn;
  bit          boot;
  bit          rdy;
  bit          irdy;
  bit          redir;
  logic [29:0] raddr;
  int          lat;
  int          obs_hs = 0;
  int          obs_pop = 0;
  logic [29:0] obs_hs_addr = '0;
  logic [29:0] obs_pop_addr = '0;
  bit          wrap_seen = 1'b0;

  function automatic logic [31:0] mem_word(logic [29:0] a);
    return ({a, 2'b00} * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: drive at posedge+1, check at the falling edge, then
  // advance the reference model by what the cycle should have done.
  task automatic tick();
    bit    deliver;
    bit    exp_rv;
    bit    hs;
    bit    pop;
    int    nstale;
    pend_t e;
    imem_req_ready = rdy;
    insn_ready     = irdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
    deliver = 1'b0;
    if (mq.size() > 0) deliver = mq[0].due <= cyc;
    imem_rsp_valid = deliver;
    imem_rsp_data  = $urandom;
    if (deliver) imem_rsp_data = mem_word(mq[0].addr);
    #4;
    nstale = 0;
    foreach (mq[i]) if (mq[i].stale) nstale++;
    exp_rv = !boot && nstale == 0 && !redir &&
             (mq.size() + buffered < DEPTH);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, exp_req);
    check("insn_valid", insn_valid, buffered > 0);
    if (buffered > 0) begin
      check("insn_addr", insn_addr, exp_insn);
      check("insn", insn, mem_word(exp_insn));
    end
    if (imem_req_valid && rdy) begin
      if (obs_hs > 0 && obs_hs_addr == 30'h3FFF_FFFF &&
          imem_req_addr == 30'h0) wrap_seen = 1'b1;
      obs_hs_addr = imem_req_addr;
      obs_hs++;
    end
    if (insn_valid && irdy) begin
      obs_pop_addr = insn_addr;
      obs_pop++;
    end
    hs  = exp_rv && rdy;
    pop = buffered > 0 && irdy;
    if (pop) begin
      exp_insn++;
      buffered--;
    end
    if (hs) begin
      mq.push_back('{exp_req, cyc + lat, 1'b0});
      exp_req++;
    end
    if (deliver) begin
      e = mq.pop_front();
      if (!e.stale && !redir) buffered++;
    end
    if (redir) begin
      buffered = 0;
      exp_req  = raddr;
      exp_insn = raddr;
      foreach (mq[i]) mq[i].stale = 1'b1;
    end
    boot = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    insn_ready     = 1'b0;
    rdy = 0; irdy = 0; redir = 0; raddr = '0; lat = 1;
    boot = 1; buffered = 0; exp_req = '0; exp_insn = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, 30'h0);
    check("rst_insn_valid", insn_valid, 1'b0);
    check("rst_insn_addr", insn_addr, 30'h0);
    check("rst_insn", insn, 32'h0);
    rst = 1'b1;

    // Streaming with single-cycle memory.
    rdy = 1; irdy = 1; lat = 1;
    repeat (20) tick();

    // Decode stall: fill from empty, then resume.
    rdy = 0; irdy = 1;
    repeat (5) tick();
    rdy = 1; irdy = 0;
    base = obs_hs;
    repeat (10) tick();
    check("stall_requests", obs_hs - base, DEPTH);
    check("stall_insn_valid", insn_valid, 1'b1);
    check("stall_req_valid", imem_req_valid, 1'b0);
    irdy = 1;
    repeat (10) tick();

    // Redirect to 0x100 with two requests outstanding.
    lat = 3;
    n = 0;
    while (mq.size() != 2 && n < 20) begin tick(); n++; end
    check("setup_two_inflight", mq.size(), 2);
    redir = 1; raddr = 30'h40;
    tick();
    redir = 0;
    check("redirect_insn_valid_low", insn_valid, 1'b0);
    base = obs_hs; n = 0;
    while (obs_hs == base && n < 20) begin tick(); n++; end
    check("redirect_first_req", obs_hs_addr, 30'h40);
    base = obs_pop; n = 0;
    while (obs_pop == base && n < 20) begin tick(); n++; end
    check("redirect_first_insn", obs_pop_addr, 30'h40);

    // Toggling memory ready, three-cycle latency.
    for (int i = 0; i < 40; i++) begin
      rdy = i[0];
      tick();
    end

    // Word address wrap at the top of the space.
    rdy = 1; lat = 1;
    redir = 1; raddr = 30'h3FFF_FFFF;
    tick();
    redir = 0;
    repeat (12) tick();
    check("pc_wrap", wrap_seen, 1'b1);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 500; i++) begin
      rdy   = ($urandom % 4) != 0;
      irdy  = ($urandom % 3) != 0;
      lat   = 1 + ($urandom % 4);
      redir = ($urandom % 32) == 0;
      raddr = 30'($urandom);
      tick();
    end
    redir = 0;

    // Reset with two responses still owed by memory.
    rdy = 1; irdy = 1; lat = 3;
    n = 0;
    while (mq.size() != 2 && n < 30) begin tick(); n++; end
    check("setup_reset_inflight", mq.size(), 2);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_req_valid", imem_req_valid, 1'b0);
    check("midrst_req_addr", imem_req_addr, 30'h0);
    check("midrst_insn_valid", insn_valid, 1'b0);
    check("midrst_insn_addr", insn_addr, 30'h0);
    check("midrst_insn", insn, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      imem_rsp_valid = mq.size() > 0;
      if (mq.size() > 0) begin
        imem_rsp_data = mem_word(mq[0].addr);
        mq.delete(0);
      end
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    mq.delete();
    buffered = 0; exp_req = '0; exp_insn = '0; boot = 1;
    rst = 1'b1;
    rdy = 1; irdy = 1; lat = 1;
    base = obs_hs; n = 0;
    while (obs_hs == base && n < 20) begin tick(); n++; end
    check("reset_restart_req", obs_hs_addr, 30'h0);
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
